// File: rtl/reset_ctrl.sv
// reset_ctrl: staged reset generator.
//   Takes the board reset RST_n, a raw push-button (btn_n) and an optional
//   watchdog, and produces two active-low resets. periph_rst_n is released
//   first and core_rst_n STAGE_DLY cycles later. Both stay low for at least
//   PULSE_LEN cycles after any reset source. rst_cause records the last source.
//
// Optional feature macro: RST_CTRL_WDOG_EN. When it is defined, the watchdog
// counter and its request are built. When it is undefined, wdog_kick is
// ignored and no watchdog reset can occur.
//
// Ports:
//   clk           in   system clock (posedge)
//   RST_n         in   board reset, asynchronous, active-low
//   btn_n         in   raw push-button, asynchronous, active-low
//   wdog_kick     in   synchronous watchdog restart strobe
//   clr_cause     in   synchronous strobe clearing rst_cause
//   periph_rst_n  out  peripheral reset, active-low, registered
//   core_rst_n    out  core reset, active-low, registered
//   rst_cause     out  00 none, 01 RST_n, 10 button, 11 watchdog
module reset_ctrl #(
  parameter int DEB_CNT   = 16,
  parameter int PULSE_LEN = 8,
  parameter int STAGE_DLY = 4,
  parameter int WDOG_LEN  = 1024
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       btn_n,
  input  logic       wdog_kick,
  input  logic       clr_cause,
  output logic       periph_rst_n,
  output logic       core_rst_n,
  output logic [1:0] rst_cause
);

  localparam int SEQ_MAX = (PULSE_LEN > STAGE_DLY) ? PULSE_LEN : STAGE_DLY;
  localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
  localparam int DEB_W   = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  localparam logic [SEQ_W-1:0] PULSE_LAST = SEQ_W'(PULSE_LEN - 1);
  localparam logic [SEQ_W-1:0] STAGE_LAST = SEQ_W'(STAGE_DLY - 1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'b00,
    ST_HOLD   = 2'b01,
    ST_REL    = 2'b10,
    ST_RUN    = 2'b11
  } state_t;

  state_t           state_r;
  logic [SEQ_W-1:0] cnt_r;
  logic             sync_q1_r;
  logic             sync_q2_r;
  logic             btn_q1_r;
  logic             btn_q2_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic             armed_r;
  logic             btn_req_r;
  logic             wdog_req_s;
  logic             req_s;
  logic [1:0]       req_cause_s;

  // RST_n release synchronizer; deassertion reaches the FSM two edges later
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sync_q1_r <= 1'b0;
      sync_q2_r <= 1'b0;
    end else begin
      sync_q1_r <= 1'b1;
      sync_q2_r <= sync_q1_r;
    end
  end

  // Push-button synchronizer (idle level is high)
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      btn_q1_r <= 1'b1;
      btn_q2_r <= 1'b1;
    end else begin
      btn_q1_r <= btn_n;
      btn_q2_r <= btn_q1_r;
    end
  end

  // Debouncer: armed it counts low samples and fires once; disarmed it waits
  // for an equally long stable high before accepting another press
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      deb_cnt_r <= '0;
      armed_r   <= 1'b1;
      btn_req_r <= 1'b0;
    end else begin
      btn_req_r <= 1'b0;
      if (armed_r) begin
        if (!btn_q2_r) begin
          if (deb_cnt_r == DEB_LAST) begin
            btn_req_r <= 1'b1;
            armed_r   <= 1'b0;
            deb_cnt_r <= '0;
          end else begin
            deb_cnt_r <= deb_cnt_r + DEB_W'(1);
          end
        end else begin
          deb_cnt_r <= '0;
        end
      end else begin
        if (btn_q2_r) begin
          if (deb_cnt_r == DEB_LAST) begin
            armed_r   <= 1'b1;
            deb_cnt_r <= '0;
          end else begin
            deb_cnt_r <= deb_cnt_r + DEB_W'(1);
          end
        end else begin
          deb_cnt_r <= '0;
        end
      end
    end
  end

`ifdef RST_CTRL_WDOG_EN
  localparam int WD_W = (WDOG_LEN > 1) ? $clog2(WDOG_LEN) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_LEN - 1);

  logic [WD_W-1:0] wdog_cnt_r;

  // Watchdog counter: runs only in RUN; a kick or the terminal count clears it
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      wdog_cnt_r <= '0;
    end else if ((state_r != ST_RUN) || wdog_kick || wdog_req_s) begin
      wdog_cnt_r <= '0;
    end else begin
      wdog_cnt_r <= wdog_cnt_r + WD_W'(1);
    end
  end

  // Watchdog request at terminal count; a same-cycle kick suppresses it
  always_comb begin
    wdog_req_s = 1'b0;
    if ((state_r == ST_RUN) && !wdog_kick && (wdog_cnt_r == WD_LAST)) begin
      wdog_req_s = 1'b1;
    end else begin
      wdog_req_s = 1'b0;
    end
  end
`else
  logic unused_wdog_s;
  assign unused_wdog_s = wdog_kick & (WDOG_LEN > 0);
  assign wdog_req_s    = 1'b0;
`endif

  // Merge reset requests; the button wins the cause code when both fire
  always_comb begin
    req_s       = btn_req_r | wdog_req_s;
    req_cause_s = 2'b00;
    if (btn_req_r) begin
      req_cause_s = 2'b10;
    end else if (wdog_req_s) begin
      req_cause_s = 2'b11;
    end else begin
      req_cause_s = 2'b00;
    end
  end

  // Reset sequencer with registered reset outputs and cause register
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_r      <= ST_ASSERT;
      cnt_r        <= '0;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      rst_cause    <= 2'b01;
    end else if (req_s && (state_r != ST_ASSERT)) begin
      // A request restarts the pulse from any post-ASSERT state
      state_r      <= ST_HOLD;
      cnt_r        <= '0;
      periph_rst_n <= 1'b0;
      core_rst_n   <= 1'b0;
      rst_cause    <= req_cause_s;
    end else begin
      if (clr_cause) begin
        rst_cause <= 2'b00;
      end
      case (state_r)
        ST_ASSERT: begin
          periph_rst_n <= 1'b0;
          core_rst_n   <= 1'b0;
          cnt_r        <= '0;
          if (sync_q2_r) begin
            state_r <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt_r == PULSE_LAST) begin
            state_r      <= ST_REL;
            cnt_r        <= '0;
            periph_rst_n <= 1'b1;
          end else begin
            cnt_r <= cnt_r + SEQ_W'(1);
          end
        end
        ST_REL: begin
          if (cnt_r == STAGE_LAST) begin
            state_r    <= ST_RUN;
            cnt_r      <= '0;
            core_rst_n <= 1'b1;
          end else begin
            cnt_r <= cnt_r + SEQ_W'(1);
          end
        end
        ST_RUN: begin
          cnt_r <= '0;
        end
        default: begin
          state_r      <= ST_ASSERT;
          cnt_r        <= '0;
          periph_rst_n <= 1'b0;
          core_rst_n   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_ctrl.sv
// Directed testbench for reset_ctrl. The main instance uses default timing
// with WDOG_LEN=32. A second instance with DEB_CNT=2 is fast enough to
// deliver a second button request while the first pulse is still in HOLD.
module tb_reset_ctrl;

  logic       clk;
  logic       RST_n;
  logic       btn_n;
  logic       wdog_kick;
  logic       clr_cause;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic [1:0] rst_cause;
  logic       btn2_n;
  logic       periph2;
  logic       core2;
  logic [1:0] cause2;

  int n_cmp = 0;
  int n_err = 0;

  reset_ctrl #(.DEB_CNT(16), .PULSE_LEN(8), .STAGE_DLY(4), .WDOG_LEN(32)) dut (
    .clk(clk), .RST_n(RST_n), .btn_n(btn_n), .wdog_kick(wdog_kick),
    .clr_cause(clr_cause), .periph_rst_n(periph_rst_n),
    .core_rst_n(core_rst_n), .rst_cause(rst_cause)
  );

  reset_ctrl #(.DEB_CNT(2), .PULSE_LEN(8), .STAGE_DLY(4), .WDOG_LEN(32)) dut_fast (
    .clk(clk), .RST_n(RST_n), .btn_n(btn2_n), .wdog_kick(1'b1),
    .clr_cause(1'b0), .periph_rst_n(periph2),
    .core_rst_n(core2), .rst_cause(cause2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Release RST_n and record the edge index (E0 = first edge) of each release
  task automatic power_up(output int p_edge, output int c_edge);
    p_edge = -1;
    c_edge = -1;
    RST_n = 1'b1;
    for (int e = 0; e < 40 && c_edge < 0; e++) begin
      tick();
      if (periph_rst_n === 1'b1 && p_edge < 0) p_edge = e;
      if (core_rst_n === 1'b1 && c_edge < 0) c_edge = e;
    end
  endtask

  task automatic wait_run();
    for (int i = 0; i < 40 && core_rst_n !== 1'b1; i++) tick();
    n_cmp++;
    if (core_rst_n !== 1'b1) begin
      n_err++;
      $display("FAIL wait_run: core_rst_n=%b required 1", core_rst_n);
    end
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (periph_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_periph: got %b want 0", periph_rst_n); end
    n_cmp++;
    if (core_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_core: got %b want 0", core_rst_n); end
    n_cmp++;
    if (rst_cause !== 2'b01) begin n_err++; $display("FAIL reset_cause: got %b want 01", rst_cause); end
  endtask

  task automatic test_power_on();
    int p_e, c_e;
    power_up(p_e, c_e);
    n_cmp++;
    if (p_e !== 10) begin n_err++; $display("FAIL pon_periph_edge: got %0d want 10", p_e); end
    n_cmp++;
    if (c_e !== 14) begin n_err++; $display("FAIL pon_core_edge: got %0d want 14", c_e); end
    n_cmp++;
    if (rst_cause !== 2'b01) begin n_err++; $display("FAIL pon_cause: got %b want 01", rst_cause); end
  endtask

  task automatic test_clr_cause();
    clr_cause = 1'b1;
    tick();
    clr_cause = 1'b0;
    n_cmp++;
    if (rst_cause !== 2'b00) begin n_err++; $display("FAIL clr_cause: got %b want 00", rst_cause); end
    tick();
    n_cmp++;
    if (rst_cause !== 2'b00) begin n_err++; $display("FAIL clr_sticky: got %b want 00", rst_cause); end
  endtask

  // Low 10, high 2, low 20: only the 20-cycle press is long enough
  task automatic test_bounce();
    int falls = 0, fall_e = -1, rise_e = -1, cfall_e = -1, crise_e = -1;
    logic pp = periph_rst_n, pc = core_rst_n;
    for (int i = 0; i < 80; i++) begin
      btn_n = (i < 10) ? 1'b0 : (i < 12) ? 1'b1 : (i < 32) ? 1'b0 : 1'b1;
      tick();
      if (pp && !periph_rst_n) begin falls++; if (fall_e < 0) fall_e = i; end
      if (!pp && periph_rst_n && rise_e < 0) rise_e = i;
      if (pc && !core_rst_n && cfall_e < 0) cfall_e = i;
      if (!pc && core_rst_n && crise_e < 0) crise_e = i;
      pp = periph_rst_n;
      pc = core_rst_n;
    end
    n_cmp++;
    if (falls !== 1) begin n_err++; $display("FAIL bounce_count: got %0d resets want 1", falls); end
    n_cmp++;
    if (fall_e !== 30) begin n_err++; $display("FAIL bounce_assert_edge: got %0d want 30", fall_e); end
    n_cmp++;
    if (cfall_e !== 30) begin n_err++; $display("FAIL bounce_core_assert: got %0d want 30", cfall_e); end
    n_cmp++;
    if (rise_e !== 38) begin n_err++; $display("FAIL bounce_periph_rel: got %0d want 38", rise_e); end
    n_cmp++;
    if (crise_e !== 42) begin n_err++; $display("FAIL bounce_core_rel: got %0d want 42", crise_e); end
    n_cmp++;
    if (rst_cause !== 2'b10) begin n_err++; $display("FAIL bounce_cause: got %b want 10", rst_cause); end
  endtask

  // clr_cause alone clears; clr_cause on the request edge loses to the request
  task automatic test_clr_with_request();
    for (int i = 0; i < 40; i++) begin
      btn_n     = (i < 25) ? 1'b0 : 1'b1;
      clr_cause = (i == 5 || i == 18) ? 1'b1 : 1'b0;
      tick();
      if (i == 5) begin
        n_cmp++;
        if (rst_cause !== 2'b00) begin n_err++; $display("FAIL clrreq_clear: got %b want 00", rst_cause); end
      end
      if (i == 18) begin
        n_cmp++;
        if (rst_cause !== 2'b10) begin n_err++; $display("FAIL clrreq_cause: got %b want 10", rst_cause); end
        n_cmp++;
        if (periph_rst_n !== 1'b0) begin n_err++; $display("FAIL clrreq_assert: got %b want 0", periph_rst_n); end
      end
    end
    clr_cause = 1'b0;
    btn_n = 1'b1;
  endtask

  // Fast instance: second request lands in HOLD and restarts the pulse
  task automatic test_restart_in_hold();
    int falls = 0, fall_e = -1, rise_e = -1, crise_e = -1;
    logic pp = periph2, pc = core2;
    for (int i = 0; i < 60; i++) begin
      btn2_n = (i < 4) ? 1'b0 : (i < 6) ? 1'b1 : (i < 40) ? 1'b0 : 1'b1;
      tick();
      if (pp && !periph2) begin falls++; if (fall_e < 0) fall_e = i; end
      if (!pp && periph2 && rise_e < 0) rise_e = i;
      if (!pc && core2 && crise_e < 0) crise_e = i;
      pp = periph2;
      pc = core2;
    end
    n_cmp++;
    if (fall_e !== 4) begin n_err++; $display("FAIL hold_first_assert: got %0d want 4", fall_e); end
    n_cmp++;
    if (falls !== 1) begin n_err++; $display("FAIL hold_falls: got %0d want 1", falls); end
    n_cmp++;
    if (rise_e !== 18) begin n_err++; $display("FAIL hold_periph_rel: got %0d want 18", rise_e); end
    n_cmp++;
    if (crise_e !== 22) begin n_err++; $display("FAIL hold_core_rel: got %0d want 22", crise_e); end
    n_cmp++;
    if (cause2 !== 2'b10) begin n_err++; $display("FAIL hold_cause: got %b want 10", cause2); end
  endtask

  task automatic test_rst_during_rel();
    int p_e, c_e;
    RST_n = 1'b0;
    tick();
    tick();
    RST_n = 1'b1;
    repeat (12) tick();
    n_cmp++;
    if ({periph_rst_n, core_rst_n} !== 2'b10) begin
      n_err++; $display("FAIL rel_state: got %b want 10", {periph_rst_n, core_rst_n});
    end
    RST_n = 1'b0;
    #1;
    n_cmp++;
    if ({periph_rst_n, core_rst_n} !== 2'b00) begin
      n_err++; $display("FAIL rel_abort: got %b want 00", {periph_rst_n, core_rst_n});
    end
    n_cmp++;
    if (rst_cause !== 2'b01) begin n_err++; $display("FAIL rel_abort_cause: got %b want 01", rst_cause); end
    @(negedge clk);
    repeat (3) tick();
    power_up(p_e, c_e);
    n_cmp++;
    if (p_e !== 10) begin n_err++; $display("FAIL replay_periph_edge: got %0d want 10", p_e); end
    n_cmp++;
    if (c_e !== 14) begin n_err++; $display("FAIL replay_core_edge: got %0d want 14", c_e); end
  endtask

`ifdef RST_CTRL_WDOG_EN
  task automatic test_wdog_timeout();
    int fall_e = -1;
    for (int i = 1; i <= 40 && fall_e < 0; i++) begin
      wdog_kick = 1'b0;
      tick();
      if (periph_rst_n === 1'b0) fall_e = i;
    end
    wdog_kick = 1'b1;
    n_cmp++;
    if (fall_e !== 32) begin n_err++; $display("FAIL wdog_edge: got %0d want 32", fall_e); end
    n_cmp++;
    if (rst_cause !== 2'b11) begin n_err++; $display("FAIL wdog_cause: got %b want 11", rst_cause); end
    wait_run();
  endtask

  task automatic test_wdog_kicks();
    int lows = 0;
    for (int i = 1; i <= 100; i++) begin
      wdog_kick = (i % 20 == 0) ? 1'b1 : 1'b0;
      tick();
      if (periph_rst_n !== 1'b1) lows++;
    end
    // Kick exactly on the terminal-count cycle
    for (int i = 1; i <= 40; i++) begin
      wdog_kick = (i == 32 || i > 35) ? 1'b1 : 1'b0;
      tick();
      if (periph_rst_n !== 1'b1) lows++;
    end
    wdog_kick = 1'b1;
    n_cmp++;
    if (lows !== 0) begin n_err++; $display("FAIL wdog_kicked: got %0d reset cycles want 0", lows); end
  endtask

  task automatic test_simultaneous();
    int fall_e = -1;
    for (int i = 1; i <= 40 && fall_e < 0; i++) begin
      wdog_kick = 1'b0;
      btn_n = (i >= 14) ? 1'b0 : 1'b1;
      tick();
      if (periph_rst_n === 1'b0) fall_e = i;
    end
    wdog_kick = 1'b1;
    btn_n = 1'b1;
    n_cmp++;
    if (fall_e !== 32) begin n_err++; $display("FAIL simul_edge: got %0d want 32", fall_e); end
    n_cmp++;
    if (rst_cause !== 2'b10) begin n_err++; $display("FAIL simul_cause: got %b want 10", rst_cause); end
    wait_run();
  endtask
`else
  task automatic test_wdog_disabled();
    int lows = 0;
    for (int i = 0; i < 100; i++) begin
      wdog_kick = 1'b0;
      tick();
      if (periph_rst_n !== 1'b1 || core_rst_n !== 1'b1) lows++;
    end
    wdog_kick = 1'b1;
    n_cmp++;
    if (lows !== 0) begin n_err++; $display("FAIL wdog_off: got %0d reset cycles want 0", lows); end
    n_cmp++;
    if (rst_cause !== 2'b01) begin n_err++; $display("FAIL wdog_off_cause: got %b want 01", rst_cause); end
  endtask
`endif

  initial begin
    RST_n     = 1'b0;
    btn_n     = 1'b1;
    btn2_n    = 1'b1;
    wdog_kick = 1'b1;
    clr_cause = 1'b0;
    test_reset();
    test_power_on();
    test_clr_cause();
    test_bounce();
    test_clr_with_request();
    test_restart_in_hold();
    test_rst_during_rel();
`ifdef RST_CTRL_WDOG_EN
    test_wdog_timeout();
    test_wdog_kicks();
    test_simultaneous();
`else
    test_wdog_disabled();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
